count_phase_sequencer: RTL and testbench
========================================

// Module: count_phase_sequencer
// PURPOSE
//  Sequences a two-phase counting datapath. Phase A counts cnt_a from 0 to LIMIT_A.
//  Phase B then starts cnt_b at cnt_a's final value and counts it to LIMIT_B.
//  Start/abort/hold control, busy/phase status and a one-cycle done pulse let an upstream
//  controller schedule repeated count runs. Error detection is sticky; nothing is printed.
// PARAMETERS
//  WIDTH         7    width of cnt_a/cnt_b; LIMIT_A and LIMIT_B must both be <= 2**WIDTH-1
//  LIMIT_A       50   terminal value of phase A
//  LIMIT_B       100  terminal value of phase B; must be >= LIMIT_A, else err (see below)
//  AUTO_RESTART  0    1: DONE goes directly to a new run without a start pulse
// PORTS
//  clk    in   1      single clock; all state changes on the rising edge
//  rst    in   1      synchronous reset, active-high, dominates all other inputs
//  start  in   1      request a run; sampled only in IDLE or DONE
//  hold   in   1      freeze counters and state while in RUN_A/RUN_B
//  abort  in   1      terminate the current run; returns to IDLE
//  cnt_a  out  WIDTH  phase-A count (registered)
//  cnt_b  out  WIDTH  phase-B count (registered)
//  phase  out  2      00 IDLE, 01 RUN_A, 10 RUN_B, 11 DONE
//  busy   out  1      1 while in RUN_A or RUN_B
//  done   out  1      one-cycle pulse, high exactly while in DONE
//  err    out  1      sticky error flag; cleared only by rst
// BEHAVIOUR
//  Reset: state IDLE; cnt_a, cnt_b, done, err and busy all 0; phase 00. Applies at any state.
//  Input priority, highest first: rst > abort > hold > start.
//  IDLE
//   - start=1 and abort=0: clear cnt_a and cnt_b to 0; go to RUN_A.
//   - Otherwise stay in IDLE; the counters keep their last values.
//  RUN_A, hold=0
//   - cnt_a < LIMIT_A: cnt_a <= cnt_a + 1.
//   - cnt_a == LIMIT_A: cnt_b <= cnt_a (handoff load); go to RUN_B.
//  RUN_B, hold=0
//   - cnt_b < LIMIT_B: cnt_b <= cnt_b + 1.
//   - cnt_b == LIMIT_B: go to DONE.
//  hold=1 in RUN_A/RUN_B: state and both counters are unchanged. hold is ignored in IDLE/DONE.
//  DONE (lasts 1 cycle)
//   - start=1 or AUTO_RESTART=1: clear both counters; go to RUN_A.
//   - Otherwise go to IDLE. The counters keep their final values.
//  abort=1 in RUN_A, RUN_B or DONE: go to IDLE next cycle; counters are held, not cleared.
//   An abort during RUN_B produces no done pulse. abort=1 in IDLE blocks start.
//  start in RUN_A/RUN_B is ignored; it is not queued.
//  Error: in RUN_A with cnt_a > LIMIT_A, or in RUN_B with cnt_b > LIMIT_B:
//   set err and go to IDLE. This covers a misconfigured LIMIT_A > LIMIT_B, which loads
//   cnt_b above LIMIT_B at handoff and trips on the next RUN_B cycle. err does not stop
//   later runs from starting.
//  Counters never wrap, because both limits are <= 2**WIDTH-1.
//  Latency with defaults, taking E0 as the edge that samples start:
//   - RUN_A with cnt_a=0 after E0; cnt_a=50 after E50.
//   - RUN_B with cnt_b=50 after E51; cnt_b=100 after E101.
//   - DONE and done=1 after E102; IDLE after E103.
//  General case: done after edge LIMIT_A + (LIMIT_B - LIMIT_A) + 2, plus the number of held cycles.
//  busy, phase and done decode from registered state only; no combinational path from the inputs.
// TESTING
//  1. Defaults; start for 1 cycle -> phase 01 for 51 cycles, then 10 for 51 cycles; done for 1
//     cycle at E102 with cnt_a=50, cnt_b=100; back to IDLE at E103; err=0.
//  2. hold=1 for 10 cycles starting when cnt_a=20 -> cnt_a stays at 20 through the hold;
//     done moves to E112; final counts 50/100.
//  3. abort when cnt_b=75 -> IDLE next cycle; cnt_b stays at 75; no done pulse;
//     a later start clears the counters and repeats scenario 1.
//  4. rst when cnt_a=30 -> next cycle IDLE, all outputs 0; start asserted in the same cycle as rst is ignored.
//  5. LIMIT_A=60, LIMIT_B=40 -> handoff loads cnt_b=60; next cycle err=1 and IDLE;
//     err stays 1 through a further start until rst.
//  6. AUTO_RESTART=1 -> done pulses every 103 cycles back-to-back; start while busy has no effect on timing.

Source files
------------

// File: rtl/count_phase_sequencer.sv
// Two-phase counting sequencer: cnt_a counts 0..LIMIT_A, then cnt_b continues from
// cnt_a's final value up to LIMIT_B, with start/abort/hold control and a sticky error flag.
module count_phase_sequencer #(
    parameter int WIDTH        = 7,
    parameter int LIMIT_A      = 50,
    parameter int LIMIT_B      = 100,
    parameter bit AUTO_RESTART = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    input  logic             abort,
    output logic [WIDTH-1:0] cnt_a,
    output logic [WIDTH-1:0] cnt_b,
    output logic [1:0]       phase,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // Encoding doubles as the phase output code.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN_A = 2'b01,
        S_RUN_B = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [WIDTH-1:0] C_LIMIT_A = WIDTH'(LIMIT_A);
    localparam logic [WIDTH-1:0] C_LIMIT_B = WIDTH'(LIMIT_B);
    localparam logic [WIDTH-1:0] C_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] C_ZERO    = '0;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_cnt_a;
    logic [WIDTH-1:0] w_cnt_a_next;
    logic [WIDTH-1:0] r_cnt_b;
    logic [WIDTH-1:0] w_cnt_b_next;
    logic             r_err;
    logic             w_err_next;

    logic w_a_at_limit;
    logic w_a_over_limit;
    logic w_b_at_limit;
    logic w_b_over_limit;
    logic w_restart;

    assign w_a_at_limit   = (r_cnt_a == C_LIMIT_A);
    assign w_a_over_limit = (r_cnt_a >  C_LIMIT_A);
    assign w_b_at_limit   = (r_cnt_b == C_LIMIT_B);
    assign w_b_over_limit = (r_cnt_b >  C_LIMIT_B);
    assign w_restart      = start || AUTO_RESTART;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt_a <= C_ZERO;
            r_cnt_b <= C_ZERO;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt_a <= w_cnt_a_next;
            r_cnt_b <= w_cnt_b_next;
            r_err   <= w_err_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_a_next = r_cnt_a;
        w_cnt_b_next = r_cnt_b;
        w_err_next   = r_err;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_cnt_a_next = C_ZERO;
                    w_cnt_b_next = C_ZERO;
                    w_state_next = S_RUN_A;
                end
            end
            S_RUN_A: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (!hold) begin
                    if (w_a_over_limit) begin
                        w_err_next   = 1'b1;
                        w_state_next = S_IDLE;
                    end else if (w_a_at_limit) begin
                        w_cnt_b_next = r_cnt_a;
                        w_state_next = S_RUN_B;
                    end else begin
                        w_cnt_a_next = r_cnt_a + C_ONE;
                    end
                end
            end
            S_RUN_B: begin
                // A handoff value above LIMIT_B (LIMIT_A > LIMIT_B) trips here.
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (!hold) begin
                    if (w_b_over_limit) begin
                        w_err_next   = 1'b1;
                        w_state_next = S_IDLE;
                    end else if (w_b_at_limit) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_cnt_b_next = r_cnt_b + C_ONE;
                    end
                end
            end
            S_DONE: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (w_restart) begin
                    w_cnt_a_next = C_ZERO;
                    w_cnt_b_next = C_ZERO;
                    w_state_next = S_RUN_A;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign cnt_a = r_cnt_a;
    assign cnt_b = r_cnt_b;
    assign phase = r_state;
    assign busy  = (r_state == S_RUN_A) || (r_state == S_RUN_B);
    assign done  = (r_state == S_DONE);
    assign err   = r_err;

endmodule

// File: tb/tb_count_phase_sequencer.sv
// Directed bench for count_phase_sequencer: default, misconfigured-limit and auto-restart instances.
module tb_count_phase_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // default instance
    logic       rst = 1'b0, start = 1'b0, hold = 1'b0, abort = 1'b0;
    logic [6:0] cnt_a, cnt_b;
    logic [1:0] phase;
    logic       busy, done, err;

    // LIMIT_A > LIMIT_B instance
    logic       e_rst = 1'b0, e_start = 1'b0, e_hold = 1'b0, e_abort = 1'b0;
    logic [6:0] e_cnt_a, e_cnt_b;
    logic [1:0] e_phase;
    logic       e_busy, e_done, e_err;

    // AUTO_RESTART instance
    logic       u_rst = 1'b0, u_start = 1'b0, u_hold = 1'b0, u_abort = 1'b0;
    logic [6:0] u_cnt_a, u_cnt_b;
    logic [1:0] u_phase;
    logic       u_busy, u_done, u_err;

    count_phase_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .abort(abort),
        .cnt_a(cnt_a), .cnt_b(cnt_b), .phase(phase), .busy(busy), .done(done), .err(err)
    );

    count_phase_sequencer #(.WIDTH(7), .LIMIT_A(60), .LIMIT_B(40), .AUTO_RESTART(1'b0)) dut_err (
        .clk(clk), .rst(e_rst), .start(e_start), .hold(e_hold), .abort(e_abort),
        .cnt_a(e_cnt_a), .cnt_b(e_cnt_b), .phase(e_phase), .busy(e_busy), .done(e_done), .err(e_err)
    );

    count_phase_sequencer #(.WIDTH(7), .LIMIT_A(50), .LIMIT_B(100), .AUTO_RESTART(1'b1)) dut_auto (
        .clk(clk), .rst(u_rst), .start(u_start), .hold(u_hold), .abort(u_abort),
        .cnt_a(u_cnt_a), .cnt_b(u_cnt_b), .phase(u_phase), .busy(u_busy), .done(u_done), .err(u_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; e_rst = 1'b1; u_rst = 1'b1;
        tick(); tick();
        rst = 1'b0; e_rst = 1'b0; u_rst = 1'b0;
        n_total++; if ({phase, busy, done, err} !== 5'b0) $display("FAIL reset_status: got %b expected 00000", {phase, busy, done, err}); else n_pass++;
        n_total++; if (cnt_a !== 7'd0) $display("FAIL reset_cnt_a: got %0d expected 0", cnt_a); else n_pass++;
        n_total++; if (cnt_b !== 7'd0) $display("FAIL reset_cnt_b: got %0d expected 0", cnt_b); else n_pass++;
        n_total++; if (e_err !== 1'b0) $display("FAIL reset_err_inst: got %0d expected 0", e_err); else n_pass++;
        tick();
        n_total++; if (u_phase !== 2'd0) $display("FAIL auto_idle_without_start: got %0d expected 0", u_phase); else n_pass++;
        $display("test_reset: phase=%0d cnt_a=%0d cnt_b=%0d", phase, cnt_a, cnt_b);
    endtask

    // start at E0, observe after E0..E103
    task automatic test_single_run(input string tag);
        int a_cyc = 0, b_cyc = 0, done_edge = -1, done_cnt = 0;
        logic [6:0] da = '0, db = '0, fa = '1, fb = '1;
        logic status_bad = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 0; e <= 103; e++) begin
            if (e == 0) begin fa = cnt_a; fb = cnt_b; end
            if (phase == 2'd1) a_cyc++;
            if (phase == 2'd2) b_cyc++;
            if (busy !== (phase == 2'd1 || phase == 2'd2)) status_bad = 1'b1;
            if (done !== (phase == 2'd3)) status_bad = 1'b1;
            if (done === 1'b1) begin done_cnt++; done_edge = e; da = cnt_a; db = cnt_b; end
            if (e < 103) tick();
        end
        n_total++; if ({fa, fb} !== 14'd0) $display("FAIL %s_start_clears: got %0d/%0d expected 0/0", tag, fa, fb); else n_pass++;
        n_total++; if (a_cyc != 51) $display("FAIL %s_run_a_cycles: got %0d expected 51", tag, a_cyc); else n_pass++;
        n_total++; if (b_cyc != 51) $display("FAIL %s_run_b_cycles: got %0d expected 51", tag, b_cyc); else n_pass++;
        n_total++; if (done_edge != 102) $display("FAIL %s_done_edge: got %0d expected 102", tag, done_edge); else n_pass++;
        n_total++; if (done_cnt != 1) $display("FAIL %s_done_pulses: got %0d expected 1", tag, done_cnt); else n_pass++;
        n_total++; if (da !== 7'd50 || db !== 7'd100) $display("FAIL %s_final_counts: got %0d/%0d expected 50/100", tag, da, db); else n_pass++;
        n_total++; if (phase !== 2'd0) $display("FAIL %s_idle_after_done: got %0d expected 0", tag, phase); else n_pass++;
        n_total++; if (status_bad !== 1'b0) $display("FAIL %s_busy_done_decode: got %0d expected 0", tag, status_bad); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL %s_err: got %0d expected 0", tag, err); else n_pass++;
        $display("%s: run_a=%0d run_b=%0d done_edge=%0d final=%0d/%0d", tag, a_cyc, b_cyc, done_edge, da, db);
    endtask

    task automatic test_hold();
        int e = 0, done_edge = -1;
        logic hold_bad = 1'b0;
        logic [6:0] da = '0, db = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) begin tick(); e++; end
        n_total++; if (cnt_a !== 7'd20) $display("FAIL hold_pre_cnt_a: got %0d expected 20", cnt_a); else n_pass++;
        hold = 1'b1;
        repeat (10) begin
            tick(); e++;
            if (cnt_a !== 7'd20 || phase !== 2'd1) hold_bad = 1'b1;
        end
        hold = 1'b0;
        n_total++; if (hold_bad !== 1'b0) $display("FAIL hold_freeze: got %0d expected 0", hold_bad); else n_pass++;
        while (e < 200 && done_edge < 0) begin
            tick(); e++;
            if (done === 1'b1) begin done_edge = e; da = cnt_a; db = cnt_b; end
        end
        n_total++; if (done_edge != 112) $display("FAIL hold_done_edge: got %0d expected 112", done_edge); else n_pass++;
        n_total++; if (da !== 7'd50 || db !== 7'd100) $display("FAIL hold_final_counts: got %0d/%0d expected 50/100", da, db); else n_pass++;
        tick();
        $display("test_hold: done_edge=%0d final=%0d/%0d", done_edge, da, db);
    endtask

    task automatic test_abort();
        int e = 0;
        logic idle_bad = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (e < 150 && !(phase == 2'd2 && cnt_b == 7'd75)) begin tick(); e++; end
        n_total++; if (e != 76) $display("FAIL abort_reach_75: got edge %0d expected 76", e); else n_pass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_total++; if (phase !== 2'd0 || busy !== 1'b0) $display("FAIL abort_to_idle: got phase %0d busy %0d expected 0/0", phase, busy); else n_pass++;
        n_total++; if (cnt_b !== 7'd75 || cnt_a !== 7'd50) $display("FAIL abort_counts_held: got %0d/%0d expected 50/75", cnt_a, cnt_b); else n_pass++;
        repeat (40) begin
            tick();
            if (done !== 1'b0 || phase !== 2'd0 || cnt_b !== 7'd75) idle_bad = 1'b1;
        end
        n_total++; if (idle_bad !== 1'b0) $display("FAIL abort_no_done: got %0d expected 0", idle_bad); else n_pass++;
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        n_total++; if (phase !== 2'd0) $display("FAIL abort_blocks_start: got %0d expected 0", phase); else n_pass++;
        $display("test_abort: phase=%0d cnt_a=%0d cnt_b=%0d", phase, cnt_a, cnt_b);
    endtask

    task automatic test_reset_midrun();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        n_total++; if (cnt_a !== 7'd30) $display("FAIL rst_pre_cnt_a: got %0d expected 30", cnt_a); else n_pass++;
        rst = 1'b1; start = 1'b1;
        tick();
        n_total++; if ({phase, busy, done, err} !== 5'b0) $display("FAIL rst_mid_status: got %b expected 00000", {phase, busy, done, err}); else n_pass++;
        n_total++; if (cnt_a !== 7'd0 || cnt_b !== 7'd0) $display("FAIL rst_mid_counts: got %0d/%0d expected 0/0", cnt_a, cnt_b); else n_pass++;
        rst = 1'b0; start = 1'b0;
        tick();
        n_total++; if (phase !== 2'd0) $display("FAIL rst_start_ignored: got %0d expected 0", phase); else n_pass++;
        $display("test_reset_midrun: phase=%0d cnt_a=%0d", phase, cnt_a);
    endtask

    task automatic test_error_config();
        int e = 0;
        e_start = 1'b1;
        tick();
        e_start = 1'b0;
        while (e < 100 && e_phase != 2'd2) begin tick(); e++; end
        n_total++; if (e != 61) $display("FAIL err_handoff_edge: got %0d expected 61", e); else n_pass++;
        n_total++; if (e_cnt_b !== 7'd60 || e_err !== 1'b0) $display("FAIL err_handoff_load: got cnt_b %0d err %0d expected 60/0", e_cnt_b, e_err); else n_pass++;
        tick();
        n_total++; if (e_err !== 1'b1 || e_phase !== 2'd0) $display("FAIL err_trip: got err %0d phase %0d expected 1/0", e_err, e_phase); else n_pass++;
        e_start = 1'b1;
        tick();
        e_start = 1'b0;
        n_total++; if (e_phase !== 2'd1 || e_cnt_a !== 7'd0 || e_err !== 1'b1) $display("FAIL err_sticky_restart: got phase %0d cnt_a %0d err %0d expected 1/0/1", e_phase, e_cnt_a, e_err); else n_pass++;
        e_rst = 1'b1;
        tick();
        e_rst = 1'b0;
        n_total++; if (e_err !== 1'b0) $display("FAIL err_cleared_by_rst: got %0d expected 0", e_err); else n_pass++;
        $display("test_error_config: handoff_edge=%0d err=%0d", e, e_err);
    endtask

    task automatic test_back_to_back();
        int n_done = 0;
        int edges[4] = '{-1, -1, -1, -1};
        u_start = 1'b1;
        tick();
        u_start = 1'b0;
        for (int e = 0; e <= 320; e++) begin
            u_start = (e == 150) || (e == 240);
            if (u_done === 1'b1) begin
                if (n_done < 4) edges[n_done] = e;
                n_done++;
            end
            if (e < 320) tick();
        end
        u_start = 1'b0;
        n_total++; if (n_done != 3) $display("FAIL auto_done_count: got %0d expected 3", n_done); else n_pass++;
        n_total++; if (edges[0] != 102) $display("FAIL auto_done_0: got %0d expected 102", edges[0]); else n_pass++;
        n_total++; if (edges[1] != 205) $display("FAIL auto_done_1: got %0d expected 205", edges[1]); else n_pass++;
        n_total++; if (edges[2] != 308) $display("FAIL auto_done_2: got %0d expected 308", edges[2]); else n_pass++;
        n_total++; if (u_phase !== 2'd1 || u_cnt_a !== 7'd11) $display("FAIL auto_rerun_state: got phase %0d cnt_a %0d expected 1/11", u_phase, u_cnt_a); else n_pass++;
        u_abort = 1'b1;
        tick();
        u_abort = 1'b0;
        tick();
        n_total++; if (u_phase !== 2'd0) $display("FAIL auto_abort_idle: got %0d expected 0", u_phase); else n_pass++;
        $display("test_back_to_back: done_edges=%0d,%0d,%0d count=%0d", edges[0], edges[1], edges[2], n_done);
    endtask

    initial begin
        test_reset();
        test_single_run("test_single_run");
        test_hold();
        test_abort();
        test_single_run("test_rerun_after_abort");
        test_reset_midrun();
        test_error_config();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
